// File: rtl/bitcoin_hash_scan.sv
// Double-SHA256 nonce scanner on a shared single-port memory bus, one SHA-256 round per cycle.
// Define BITCOIN_SCAN_TARGET_EN to add the target compare (target/found/found_nonce).
module bitcoin_hash_scan #(
   parameter int NUM_NONCES = 16,
   parameter int ADDR_W     = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] message_addr,
   input  logic [ADDR_W-1:0] output_addr,
   input  logic [31:0]       nonce_base,
`ifdef BITCOIN_SCAN_TARGET_EN
   input  logic [31:0]       target,
   output logic              found,
   output logic [31:0]       found_nonce,
`endif
   output logic              done,
   output logic              busy,
   output logic              mem_clk,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_read_data
);

   typedef enum logic [3:0] {IDLE, RD1, COMP, ADD, RD2, LOAD2, LOAD3, WRITE, FIN} state_t;

   localparam logic [31:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   state_t            state;
   logic [1:0]        pass;
   logic [6:0]        cnt;
   logic [15:0]       nonce_idx;
   logic [ADDR_W-1:0] msg_q;
   logic [ADDR_W-1:0] out_q;
   logic [31:0]       base_q;
   logic [31:0]       hv [8];
   logic [31:0]       wv [8];
   logic [31:0]       mid [8];
   logic [31:0]       sum [8];
   logic [31:0]       w [16];
   logic [31:0]       hold [3];
   logic [31:0]       t1, t2, w_new, nonce_cur;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   assign mem_clk = clk;

   // Round datapath, next schedule word and the H + working-variable sums.
   always_comb begin
      t1 = wv[7] + (rotr(wv[4], 6) ^ rotr(wv[4], 11) ^ rotr(wv[4], 25))
         + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + K[cnt[5:0]] + w[0];
      t2 = (rotr(wv[0], 2) ^ rotr(wv[0], 13) ^ rotr(wv[0], 22))
         + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
      w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
            + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
      nonce_cur = base_q + {16'd0, nonce_idx};
      for (int i = 0; i < 8; i++) sum[i] = hv[i] + wv[i];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         pass <= '0;
         cnt <= '0;
         nonce_idx <= '0;
         msg_q <= '0;
         out_q <= '0;
         base_q <= '0;
         done <= 1'b0;
         busy <= 1'b0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_write_data <= '0;
         for (int i = 0; i < 8; i++) begin
            hv[i] <= '0;
            wv[i] <= '0;
            mid[i] <= '0;
         end
         for (int i = 0; i < 16; i++) w[i] <= '0;
         for (int i = 0; i < 3; i++) hold[i] <= '0;
`ifdef BITCOIN_SCAN_TARGET_EN
         found <= 1'b0;
         found_nonce <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               msg_q <= message_addr;
               out_q <= output_addr;
               base_q <= nonce_base;
               mem_addr <= message_addr;
               done <= 1'b0;
               busy <= 1'b1;
               cnt <= '0;
               nonce_idx <= '0;
`ifdef BITCOIN_SCAN_TARGET_EN
               found <= 1'b0;
               found_nonce <= '0;
`endif
               state <= RD1;
            end
            // Read data trails the address by one cycle, so word c lands in cycle c+1.
            RD1: begin
               mem_addr <= mem_addr + ADDR_W'(1);
               if (cnt != 7'd0) begin
                  for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
                  w[15] <= mem_read_data;
               end
               if (cnt == 7'd16) begin
                  for (int i = 0; i < 8; i++) begin
                     hv[i] <= IV[i];
                     wv[i] <= IV[i];
                  end
                  pass <= 2'd0;
                  cnt <= '0;
                  state <= COMP;
               end else cnt <= cnt + 7'd1;
            end
            COMP: begin
               wv[0] <= t1 + t2;
               for (int i = 1; i < 8; i++) wv[i] <= wv[i - 1];
               wv[4] <= wv[3] + t1;
               for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
               w[15] <= w_new;
               if (cnt == 7'd63) begin
                  cnt <= '0;
                  state <= ADD;
               end else cnt <= cnt + 7'd1;
            end
            ADD: begin
               for (int i = 0; i < 8; i++) hv[i] <= sum[i];
               case (pass)
                  2'd0: begin
                     for (int i = 0; i < 8; i++) mid[i] <= sum[i];
                     mem_addr <= msg_q + ADDR_W'(16);
                     cnt <= '0;
                     state <= RD2;
                  end
                  2'd1: state <= LOAD3;
                  default: begin
                     mem_we <= 1'b1;
                     mem_addr <= out_q + ADDR_W'(nonce_idx);
                     mem_write_data <= sum[0];
`ifdef BITCOIN_SCAN_TARGET_EN
                     if (!found && (sum[0] < target)) begin
                        found <= 1'b1;
                        found_nonce <= nonce_cur;
                     end
`endif
                     state <= WRITE;
                  end
               endcase
            end
            RD2: begin
               mem_addr <= mem_addr + ADDR_W'(1);
               if (cnt != 7'd0) begin
                  hold[0] <= hold[1];
                  hold[1] <= hold[2];
                  hold[2] <= mem_read_data;
               end
               if (cnt == 7'd3) state <= LOAD2;
               else cnt <= cnt + 7'd1;
            end
            // Second block: header tail, nonce, then padding for an 80-byte message.
            LOAD2: begin
               for (int i = 0; i < 8; i++) begin
                  hv[i] <= mid[i];
                  wv[i] <= mid[i];
               end
               for (int i = 0; i < 3; i++) w[i] <= hold[i];
               w[3] <= nonce_cur;
               w[4] <= 32'h80000000;
               for (int i = 5; i < 15; i++) w[i] <= '0;
               w[15] <= 32'h00000280;
               pass <= 2'd1;
               cnt <= '0;
               state <= COMP;
            end
            LOAD3: begin
               for (int i = 0; i < 8; i++) begin
                  w[i] <= hv[i];
                  hv[i] <= IV[i];
                  wv[i] <= IV[i];
               end
               w[8] <= 32'h80000000;
               for (int i = 9; i < 15; i++) w[i] <= '0;
               w[15] <= 32'h00000100;
               pass <= 2'd2;
               cnt <= '0;
               state <= COMP;
            end
            WRITE: begin
               mem_we <= 1'b0;
               if (nonce_idx == 16'(NUM_NONCES - 1)) state <= FIN;
               else begin
                  nonce_idx <= nonce_idx + 16'd1;
                  state <= LOAD2;
               end
            end
            FIN: begin
               done <= 1'b1;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bitcoin_hash_scan.sv
// Self-checking bench for bitcoin_hash_scan: a 16-nonce and a 1-nonce instance share one memory,
// and results are checked against a plain double-SHA256 model kept in the bench.
module tb_bitcoin_hash_scan;

   localparam logic [255:0] IVT = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   typedef struct {
      logic [15:0] a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start0 = 1'b0;
   logic        start1 = 1'b0;
   logic [15:0] message_addr = '0;
   logic [15:0] output_addr = '0;
   logic [31:0] nonce_base = '0;
   logic [31:0] target = '0;

   logic        d0_done, d0_busy, d0_mclk, d0_we;
   logic [15:0] d0_addr;
   logic [31:0] d0_wdata, d0_rdata;
   logic        d1_done, d1_busy, d1_mclk, d1_we;
   logic [15:0] d1_addr;
   logic [31:0] d1_wdata, d1_rdata;
`ifdef BITCOIN_SCAN_TARGET_EN
   logic        d0_found, d1_found;
   logic [31:0] d0_fnonce, d1_fnonce;
`endif

   logic [31:0] mem [0:65535];
   wr_t         wq0[$];
   wr_t         wq1[$];
   int          cyc = 0;
   int          rises0 = 0;
   logic        done0_prev = 1'b0;

   int          evals = 0;
   int          fails = 0;
   int          t0 = 0;
   int          consumed0 = 0;
   int          consumed1 = 0;
   int          rsnap = 0;
   logic [607:0] hpA, hpB;
   logic [31:0] baseB, baseD;
   logic [15:0] outB;

   always #5 clk = ~clk;

   bitcoin_hash_scan #(.NUM_NONCES(16), .ADDR_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start0),
      .message_addr(message_addr), .output_addr(output_addr), .nonce_base(nonce_base),
`ifdef BITCOIN_SCAN_TARGET_EN
      .target(target), .found(d0_found), .found_nonce(d0_fnonce),
`endif
      .done(d0_done), .busy(d0_busy), .mem_clk(d0_mclk), .mem_we(d0_we),
      .mem_addr(d0_addr), .mem_write_data(d0_wdata), .mem_read_data(d0_rdata));

   bitcoin_hash_scan #(.NUM_NONCES(1), .ADDR_W(16)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1),
      .message_addr(message_addr), .output_addr(output_addr), .nonce_base(nonce_base),
`ifdef BITCOIN_SCAN_TARGET_EN
      .target(target), .found(d1_found), .found_nonce(d1_fnonce),
`endif
      .done(d1_done), .busy(d1_busy), .mem_clk(d1_mclk), .mem_we(d1_we),
      .mem_addr(d1_addr), .mem_write_data(d1_wdata), .mem_read_data(d1_rdata));

   // Synchronous-read memory: data appears the cycle after the address.
   always @(posedge clk) begin
      d0_rdata <= mem[d0_addr];
      d1_rdata <= mem[d1_addr];
      cyc <= cyc + 1;
   end

   // Write and done-edge monitors, sampled mid-cycle.
   always @(negedge clk) begin
      if (d0_we) wq0.push_back('{d0_addr, d0_wdata});
      if (d1_we) wq1.push_back('{d1_addr, d1_wdata});
      if (d0_done && !done0_prev) rises0 = rises0 + 1;
      done0_prev = d0_done;
   end

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] s1, s2;
      logic [255:0] res;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++)
         w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
              + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      for (int i = 0; i < 8; i++) v[i] = st[255 - 32*i -: 32];
      for (int i = 0; i < 64; i++) begin
         s1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
         s2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int j = 7; j > 0; j--) v[j] = v[j-1];
         v[4] = v[4] + s1;
         v[0] = s1 + s2;
      end
      for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = st[255 - 32*i -: 32] + v[i];
      return res;
   endfunction

   // First word of SHA256(SHA256(80-byte header with nonce as word 19)).
   function automatic logic [31:0] expH0(input logic [607:0] hp, input logic [31:0] nonce);
      logic [255:0] m, d1, d2;
      m  = compress(IVT, hp[607:96]);
      d1 = compress(m, {hp[95:0], nonce, 32'h80000000, 320'd0, 32'h00000280});
      d2 = compress(IVT, {d1, 32'h80000000, 192'd0, 32'h00000100});
      return d2[255:224];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      evals++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic loadHdr(input logic [15:0] ma, input logic [607:0] hp);
      for (int i = 0; i < 19; i++) mem[16'(ma + 16'(i))] = hp[607 - 32*i -: 32];
   endtask

   // Start a run on instance sel, then scramble the inputs to prove they were latched.
   task automatic applyStimulus(input int sel, input logic [15:0] ma, input logic [15:0] oa, input logic [31:0] nb);
      @(negedge clk);
      message_addr = ma;
      output_addr = oa;
      nonce_base = nb;
      if (sel == 0) start0 = 1'b1;
      else start1 = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      rsnap = rises0;
      start0 = 1'b0;
      start1 = 1'b0;
      message_addr = 16'($urandom);
      output_addr = 16'($urandom);
      nonce_base = $urandom;
   endtask

   task automatic waitDone(input int sel, input int lat, input string tag);
      while (((sel == 0) ? d0_done : d1_done) !== 1'b1 && (cyc - t0) < lat + 50) @(negedge clk);
      checkOutput(tag, 32'(cyc - t0), 32'(lat));
      checkOutput({tag, "_busy_low"}, {31'd0, (sel == 0) ? d0_busy : d1_busy}, 32'd0);
   endtask

   task automatic checkWrites(input int sel, input string tag, input logic [607:0] hp,
                              input logic [31:0] nb, input logic [15:0] oa, input int n);
      int avail;
      wr_t e;
      avail = (sel == 0) ? wq0.size() - consumed0 : wq1.size() - consumed1;
      checkOutput({tag, "_count"}, 32'(avail), 32'(n));
      for (int i = 0; i < n && i < avail; i++) begin
         e = (sel == 0) ? wq0[consumed0 + i] : wq1[consumed1 + i];
         checkOutput($sformatf("%s_addr%0d", tag, i), {16'd0, e.a}, {16'd0, 16'(oa + 16'(i))});
         checkOutput($sformatf("%s_data%0d", tag, i), e.d, expH0(hp, nb + 32'(i)));
      end
      if (sel == 0) consumed0 = wq0.size();
      else consumed1 = wq1.size();
   endtask

`ifdef BITCOIN_SCAN_TARGET_EN
   task automatic checkFound(input string tag, input logic [607:0] hp, input logic [31:0] nb, input logic [31:0] tg);
      logic        ef = 1'b0;
      logic [31:0] en = '0;
      for (int i = 0; i < 16; i++)
         if (!ef && expH0(hp, nb + 32'(i)) < tg) begin
            ef = 1'b1;
            en = nb + 32'(i);
         end
      checkOutput({tag, "_found"}, {31'd0, d0_found}, {31'd0, ef});
      checkOutput({tag, "_found_nonce"}, d0_fnonce, en);
   endtask
`endif

   initial begin
      for (int i = 0; i < 19; i++) hpA[607 - 32*i -: 32] = 32'h01234567 + 32'(i);
      for (int i = 0; i < 19; i++) hpB[607 - 32*i -: 32] = $urandom;
      loadHdr(16'h0100, hpA);
      loadHdr(16'h0200, hpB);

      // Reset state
      #12;
      checkOutput("rst_done", {31'd0, d0_done}, 32'd0);
      checkOutput("rst_busy", {31'd0, d0_busy}, 32'd0);
      checkOutput("rst_we", {31'd0, d0_we}, 32'd0);
      checkOutput("rst_addr", {16'd0, d0_addr}, 32'd0);
      checkOutput("rst_wdata", d0_wdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Run A: the reference header, 16 nonces from 0
      target = 32'hFFFFFFFF;
      applyStimulus(0, 16'h0100, 16'h4000, 32'd0);
      checkOutput("A_busy", {31'd0, d0_busy}, 32'd1);
      waitDone(0, 2215, "A_latency");
      checkWrites(0, "A", hpA, 32'd0, 16'h4000, 16);
`ifdef BITCOIN_SCAN_TARGET_EN
      checkFound("A", hpA, 32'd0, 32'hFFFFFFFF);
`endif
      repeat (5) @(negedge clk);
      checkOutput("A_done_hold", {31'd0, d0_done}, 32'd1);

      // Single-nonce instance: nonce and address wrap, then nonce 0
      applyStimulus(1, 16'h0100, 16'hFFFF, 32'hFFFFFFFF);
      waitDone(1, 220, "N1_latency");
      checkWrites(1, "N1wrap", hpA, 32'hFFFFFFFF, 16'hFFFF, 1);
      applyStimulus(1, 16'h0100, 16'h5000, 32'd0);
      waitDone(1, 220, "N1b_latency");
      checkWrites(1, "N1zero", hpA, 32'd0, 16'h5000, 1);

      // Run B: back-to-back, new random header, extra start pulses ignored
      baseB = $urandom;
      outB = 16'h6000 + 16'($urandom_range(0, 255));
      target = 32'd0;
      applyStimulus(0, 16'h0200, outB, baseB);
      checkOutput("B_done_cleared", {31'd0, d0_done}, 32'd0);
      checkOutput("B_busy", {31'd0, d0_busy}, 32'd1);
      repeat (9) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (489) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      checkOutput("B_busy_mid", {31'd0, d0_busy}, 32'd1);
      waitDone(0, 2215, "B_latency");
      checkWrites(0, "B", hpB, baseB, outB, 16);
      repeat (20) @(negedge clk);
      checkOutput("B_done_once", 32'(rises0 - rsnap), 32'd1);
`ifdef BITCOIN_SCAN_TARGET_EN
      checkFound("B", hpB, baseB, 32'd0);
`endif

      // Run C: reset at cycle 700 aborts the run
      applyStimulus(0, 16'h0100, 16'h7000, 32'h12345678);
      repeat (699) @(posedge clk);
      #3;
      reset_n = 1'b0;
      rsnap = wq0.size();
      #1;
      checkOutput("C_rst_done", {31'd0, d0_done}, 32'd0);
      checkOutput("C_rst_busy", {31'd0, d0_busy}, 32'd0);
      checkOutput("C_rst_we", {31'd0, d0_we}, 32'd0);
      checkOutput("C_rst_addr", {16'd0, d0_addr}, 32'd0);
      checkOutput("C_rst_wdata", d0_wdata, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (50) @(negedge clk);
      checkOutput("C_no_write_after_reset", 32'(wq0.size()), 32'(rsnap));
      consumed0 = wq0.size();

      // Run D: fresh run after the abort
      baseD = $urandom;
      applyStimulus(0, 16'h0200, 16'h0010, baseD);
      waitDone(0, 2215, "D_latency");
      checkWrites(0, "D", hpB, baseD, 16'h0010, 16);

      $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
      $finish;
   end

endmodule

// File: doc/bitcoin_hash_scan.md
Name: bitcoin_hash_scan

Overview:
- Parametrised next-generation nonce scanner.
- Reads a 20-word block header from shared memory and computes the first-block SHA-256 midstate once.
- Then sweeps NUM_NONCES consecutive nonces from a runtime base through one time-multiplexed SHA-256 round engine, computing SHA256(SHA256(header)) per nonce.
- Writes final-digest H0 for nonce n to output_addr+n; sits beside the existing hash blocks on the same single-port memory bus.

Parameters:
- NUM_NONCES, 16, nonces per run; legal range 1..65535.
- ADDR_W, 16, memory address width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  run request; sampled in IDLE only
- message_addr  in  ADDR_W  header base (words 0..18 used)
- output_addr  in  ADDR_W  result base
- nonce_base  in  32  first nonce, latched at start
- done  out  1  run complete
- busy  out  1  high from start accept until done rises
- mem_clk  out  1  equals clk
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  address
- mem_write_data  out  32  write data
- mem_read_data  in  32  read data; valid one cycle after mem_addr is presented

Behaviour:
- Reset: state IDLE.
  - done=0, busy=0, mem_we=0, mem_addr=0, mem_write_data=0.
  - All hash registers are cleared.
  - Reset asserted mid-run aborts immediately; no further writes occur.
- IDLE: start=1 latches message_addr, output_addr and nonce_base, clears done, sets busy.
- start while busy is ignored.
- RD1 (17 cycles): issue reads of words 0..15; load the W[0..15] shift register as data returns.
- COMP (64 cycles): one SHA-256 round per cycle.
  - Rolling 16-entry W schedule.
  - K constants from an internal ROM.
  - All additions mod 2^32.
- ADD (1 cycle): H += a..h.
  - First pass: the result is stored as the midstate.
  - Later passes: H is restarted from the IV or the midstate as required.
- RD2 (4 cycles): read words 16..18 into a hold register once per run.
- Per nonce n, the second block is:
  - words 16..18
  - nonce_base+n (mod 2^32)
  - 0x80000000
  - ten zero words
  - 0x00000280
- Second block: LOAD (1 cycle, H=midstate), COMP, ADD.
- Third block:
  - Message: the 8-word digest, 0x80000000, six zeros, 0x00000100.
  - Sequence: LOAD (H=IV), COMP, ADD.
- WRITE (1 cycle): mem_we=1, mem_addr=output_addr+n (mod 2^ADDR_W), mem_write_data=H0.
  - mem_we is high in WRITE only.
- Cost per nonce is exactly 133 cycles.
- After the last nonce, done=1 and busy=0 on the next cycle.
  - done rises exactly 87+133*NUM_NONCES cycles after the start-sampling edge.
  - done holds until the next accepted start.
- Boundaries:
  - NUM_NONCES=1 performs one write.
  - nonce_base=0xFFFFFFFF wraps the nonce to 0.
  - The address of the final write wraps modulo 2^ADDR_W.
  - Inputs changing mid-run have no effect.
- No reads are issued after RD2 of a run; the memory bus is never read and written in the same cycle.

Optional Feature:
- Macro BITCOIN_SCAN_TARGET_EN.
- Defined:
  - Adds input target[31:0] and outputs found (1) and found_nonce (32); both reset to 0 and clear on start accept.
  - In each ADD of the third block, if H0_final < target (unsigned) and found==0, set found=1 and found_nonce=current nonce.
  - Writes are unchanged.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Header words 0..18 = 0x01234567+i, nonce_base=0, NUM_NONCES=16 -> 16 writes at output_addr..+15 matching a software double-SHA256 model; done at cycle 2215 after start.
- NUM_NONCES=1, nonce_base=0xFFFFFFFF, output_addr=0xFFFF -> single write to 0xFFFF with nonce 0xFFFFFFFF; second run with base 0 writes model H0 for nonce 0.
- Assert reset_n low at cycle 700 of a run -> all outputs 0 within the same cycle, no mem_we afterwards; a new start then produces correct results.
- Pulse start at cycles 10 and 500 of a run -> second pulse ignored; exactly NUM_NONCES writes, done once.
- Two back-to-back runs with different message_addr -> done clears on second start; second results match the model for the new header.
- BITCOIN_SCAN_TARGET_EN, target=0xFFFFFFFF -> found=1, found_nonce=nonce_base; target=0 -> found stays 0 after done.
